// File: rtl/tea_decrypt_sequencer.sv
// Iterative TEA block engine: one round per clock on a single datapath, ROUNDS+1 cycles from accept to out_valid.
// Holds the plaintext in DONE until out_ready; in_ready only in IDLE. TEA_ENCRYPT_EN adds a mode port for encryption.
module tea_decrypt_sequencer #(
   parameter int          ROUNDS = 32,
   parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [63:0]   in_data,
   input  logic [127:0]  in_key,
`ifdef TEA_ENCRYPT_EN
   input  logic          mode,
`endif
   output logic          out_valid,
   input  logic          out_ready,
   output logic [63:0]   out_data,
   output logic          busy
);

   localparam logic [31:0] START_SUM = 32'(ROUNDS) * DELTA;
   localparam int          CW        = $clog2(ROUNDS) + 1;
   localparam logic [CW-1:0] LAST    = CW'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [31:0]     hi;
   logic [31:0]     lo;
   logic [31:0]     sum;
   logic [127:0]    key;
   logic [CW-1:0]   rnd;
   logic            enc;

   logic [31:0]     k0, k1, k2, k3;
   logic [31:0]     dec_lo, dec_hi;
   logic [31:0]     enc_hi, enc_lo;
   logic [31:0]     sum_inc;
   logic [31:0]     rnd_hi, rnd_lo, sum_nxt;
   logic            accept;
   logic            last;

   function automatic logic [31:0] mix(input logic [31:0] v, input logic [31:0] s,
                                       input logic [31:0] ka, input logic [31:0] kb);
      return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
   endfunction

   assign k0     = key[127:96];
   assign k1     = key[95:64];
   assign k2     = key[63:32];
   assign k3     = key[31:0];
   assign accept = in_valid & in_ready;
   assign last   = (rnd == LAST);

   // Decrypt updates the low word first and feeds it straight into the high-word update.
   always_comb begin
      dec_lo  = lo - mix(hi, sum, k2, k3);
      dec_hi  = hi - mix(dec_lo, sum, k0, k1);
      sum_inc = sum + DELTA;
      enc_hi  = hi + mix(lo, sum_inc, k0, k1);
      enc_lo  = lo + mix(enc_hi, sum_inc, k2, k3);
   end

   always_comb begin
      rnd_hi  = dec_hi;
      rnd_lo  = dec_lo;
      sum_nxt = sum - DELTA;
      if (enc) begin
         rnd_hi  = enc_hi;
         rnd_lo  = enc_lo;
         sum_nxt = sum_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi  <= '0;
         lo  <= '0;
         sum <= '0;
         key <= '0;
         rnd <= '0;
         enc <= 1'b0;
      end else if (accept) begin
         hi  <= in_data[63:32];
         lo  <= in_data[31:0];
         key <= in_key;
         rnd <= '0;
`ifdef TEA_ENCRYPT_EN
         enc <= mode;
         sum <= mode ? 32'h0 : START_SUM;
`else
         enc <= 1'b0;
         sum <= START_SUM;
`endif
      end else if (state == RUN) begin
         hi  <= rnd_hi;
         lo  <= rnd_lo;
         sum <= sum_nxt;
         rnd <= rnd + CW'(1);
      end
   end

   assign out_data = {hi, lo};

endmodule

// File: tb/tb_tea_decrypt_sequencer.sv
// Directed bench: a ROUNDS=1 and a ROUNDS=32 instance checked against hand-computed TEA vectors.
module tb_tea_decrypt_sequencer;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready, s1_busy;
   logic [63:0]   s1_in_data, s1_out_data;
   logic [127:0]  s1_in_key;

   logic          s32_in_valid, s32_in_ready, s32_out_valid, s32_out_ready, s32_busy;
   logic [63:0]   s32_in_data, s32_out_data;
   logic [127:0]  s32_in_key;

`ifdef TEA_ENCRYPT_EN
   logic          s1_mode;
   logic          s32_mode;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tea_decrypt_sequencer #(.ROUNDS(1)) u_r1 (
      .clk(clk), .rst(rst),
      .in_valid(s1_in_valid), .in_ready(s1_in_ready),
      .in_data(s1_in_data), .in_key(s1_in_key),
`ifdef TEA_ENCRYPT_EN
      .mode(s1_mode),
`endif
      .out_valid(s1_out_valid), .out_ready(s1_out_ready),
      .out_data(s1_out_data), .busy(s1_busy)
   );

   tea_decrypt_sequencer #(.ROUNDS(32)) u_r32 (
      .clk(clk), .rst(rst),
      .in_valid(s32_in_valid), .in_ready(s32_in_ready),
      .in_data(s32_in_data), .in_key(s32_in_key),
`ifdef TEA_ENCRYPT_EN
      .mode(s32_mode),
`endif
      .out_valid(s32_out_valid), .out_ready(s32_out_ready),
      .out_data(s32_out_data), .busy(s32_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Offer one block, then scramble the inputs so only the latched copy can produce the result.
   task automatic run_blk(input int which, input logic [63:0] d, input logic [127:0] k,
                          output int cyc, output logic [63:0] res);
      if (which == 1) begin
         s1_in_valid = 1'b1; s1_in_data = d; s1_in_key = k;
      end else begin
         s32_in_valid = 1'b1; s32_in_data = d; s32_in_key = k;
      end
      tick();
      s1_in_valid  = 1'b0; s1_in_data  = ~d; s1_in_key  = ~k;
      s32_in_valid = 1'b0; s32_in_data = ~d; s32_in_key = ~k;
      cyc = 0;
      while (!((which == 1) ? s1_out_valid : s32_out_valid) && cyc < 200) begin
         tick();
         cyc++;
      end
      res = (which == 1) ? s1_out_data : s32_out_data;
   endtask

   task automatic consume(input int which);
      if (which == 1) s1_out_ready = 1'b1; else s32_out_ready = 1'b1;
      tick();
      s1_out_ready  = 1'b0;
      s32_out_ready = 1'b0;
   endtask

   initial begin
      int          cyc;
      int          seen;
      logic [63:0] res;

      s1_in_valid = 1'b0; s1_in_data = '0; s1_in_key = '0; s1_out_ready = 1'b0;
      s32_in_valid = 1'b0; s32_in_data = '0; s32_in_key = '0; s32_out_ready = 1'b0;
`ifdef TEA_ENCRYPT_EN
      s1_mode = 1'b0;
      s32_mode = 1'b0;
`endif
      repeat (3) tick();
      rst = 1'b0;
      tick();

      check("rst_in_ready",  64'(s32_in_ready),  64'd1);
      check("rst_out_valid", 64'(s32_out_valid), 64'd0);
      check("rst_out_data",  s32_out_data,       64'h0);
      check("rst_busy",      64'(s32_busy),      64'd0);
      check("rst_r1_ready",  64'(s1_in_ready),   64'd1);

      // ROUNDS=1, zero key and data
      run_blk(1, 64'h0, 128'h0, cyc, res);
      check("r1_latency", 64'(cyc), 64'd1);
      check("r1_zero",    res,      64'hE079DFBE_61C88647);
      consume(1);
      check("r1_back_idle", 64'(s1_in_ready), 64'd1);

      // k0=0x10, k2=k3=5: k2/k3 cancel, k0 lands only in the high word
      s1_out_ready = 1'b1;
      run_blk(1, 64'h0, 128'h00000010_00000000_00000005_00000005, cyc, res);
      check("r1_key_latency", 64'(cyc), 64'd1);
      check("r1_key",         res,      64'hE079DF4E_61C88647);
      tick();
      s1_out_ready = 1'b0;
      check("r1_key_consumed", 64'(s1_out_valid), 64'd0);
      check("r1_key_idle",     64'(s1_in_ready),  64'd1);

      // ROUNDS=32 standard vector, then backpressure in DONE
      run_blk(32, 64'h41EA3A0A_94BAA940, 128'h0, cyc, res);
      check("r32_latency", 64'(cyc), 64'd32);
      check("r32_plain",   res,      64'h0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_valid",    64'(s32_out_valid), 64'd1);
         check("bp_data",     s32_out_data,       64'h0);
         check("bp_in_ready", 64'(s32_in_ready),  64'd0);
         check("bp_busy",     64'(s32_busy),      64'd1);
      end
      consume(32);
      check("bp_rel_ready", 64'(s32_in_ready),  64'd1);
      check("bp_rel_valid", 64'(s32_out_valid), 64'd0);
      check("bp_rel_busy",  64'(s32_busy),      64'd0);

      // Abort a block with reset partway through
      s32_in_valid = 1'b1; s32_in_data = 64'h41EA3A0A_94BAA940; s32_in_key = 128'h0;
      tick();
      s32_in_valid = 1'b0;
      repeat (15) tick();
      check("abort_busy_before", 64'(s32_busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_in_ready",  64'(s32_in_ready),  64'd1);
      check("abort_out_valid", 64'(s32_out_valid), 64'd0);
      check("abort_busy",      64'(s32_busy),      64'd0);
      check("abort_out_data",  s32_out_data,       64'h0);
      seen = 0;
      repeat (40) begin
         tick();
         if (s32_out_valid) seen++;
      end
      check("abort_no_valid", 64'(seen), 64'd0);

      run_blk(32, 64'h41EA3A0A_94BAA940, 128'h0, cyc, res);
      check("post_abort_latency", 64'(cyc), 64'd32);
      check("post_abort_plain",   res,      64'h0);
      consume(32);

`ifdef TEA_ENCRYPT_EN
      s32_mode = 1'b1;
      run_blk(32, 64'h0, 128'h0, cyc, res);
      check("enc_latency", 64'(cyc), 64'd32);
      check("enc_cipher",  res,      64'h41EA3A0A_94BAA940);
      consume(32);
      s32_mode = 1'b0;
      run_blk(32, res, 128'h0, cyc, res);
      check("enc_roundtrip", res, 64'h0);
      consume(32);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
